pipeline_hazard_ctrl: RTL and testbench

- Control and hazard unit for the 5-step pipeline (step1 fetch, step2 decode/RF read, step3 execute, step4 memory, step5 writeback).
- Decodes the step2 instruction into register-file read-mux selects.
- Tracks in-flight destination registers in steps 3–5 and stalls step2 on read-after-write hazards. There is no forwarding.
- Handles flush on step3 redirect and full freeze on memory stall, and drives the step5 `rf_w`/`dest` writeback controls.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/pipeline_hazard_ctrl_instr_decode.sv | 51 +++++
 rtl/pipeline_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, instruction-field and pipeline-stage definitions for the
// 5-step pipeline control logic.
package cpu_pkg;

  localparam int OPC_W = 6;
  localparam int REG_W = 2;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h01;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h02;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_J     = 6'h05;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 10;
  localparam int N1_HI   = 9;
  localparam int N1_LO   = 8;
  localparam int N2_HI   = 7;
  localparam int N2_LO   = 6;
  localparam int N3_HI   = 5;
  localparam int N3_LO   = 4;
  localparam int IMM_HI  = 5;
  localparam int IMM_LO  = 0;
  localparam int ADDR_HI = 9;
  localparam int ADDR_LO = 0;

  typedef enum logic [0:0] {
    DEST_N1 = 1'b0,
    DEST_N2 = 1'b1
  } dest_sel_e;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [REG_W-1:0] dest;
  } stage_t;

  localparam stage_t STAGE_NOP = '{valid: 1'b0, we: 1'b0, dest: {REG_W{1'b0}}};

  // True when an in-flight writer targets any register the step2 instruction reads.
  function automatic logic stage_hit(input stage_t st,
                                     input logic use_a, input logic use_b, input logic use_c,
                                     input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b,
                                     input logic [REG_W-1:0] c);
    return st.valid & st.we &
           ((use_a & (st.dest == a)) | (use_b & (st.dest == b)) | (use_c & (st.dest == c)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_instr_decode.sv
// Opcode decoder: which register fields an instruction reads and writes, and
// the register-file read-mux selects for step2.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             use_n1,
  output logic             use_n2,
  output logic             use_n3,
  output logic             writes,
  output dest_sel_e        dest_sel,
  output logic             rn1_sel,
  output logic             rn2_sel
);

  // Per-opcode source/destination usage; unknown opcodes behave like a jump.
  always_comb begin
    use_n1   = 1'b0;
    use_n2   = 1'b0;
    use_n3   = 1'b0;
    writes   = 1'b0;
    dest_sel = DEST_N2;
    rn1_sel  = 1'b1;
    rn2_sel  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        use_n2   = 1'b1;
        use_n3   = 1'b1;
        writes   = 1'b1;
        dest_sel = DEST_N1;
        rn1_sel  = 1'b0;
        rn2_sel  = 1'b0;
      end
      OP_ADDI, OP_LW: begin
        use_n1 = 1'b1;
        writes = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        use_n1 = 1'b1;
        use_n2 = 1'b1;
      end
      OP_J: begin
        writes = 1'b0;
      end
      default: begin
        writes = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control/hazard unit: RAW stall detection against steps 3-5 (no
// forwarding), redirect flush, memory-stall freeze and step5 writeback controls.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int DW    = 16,
  parameter int RW    = 2,
  parameter int CNT_W = 16
)(
  input  logic             clock,
  input  logic             reset,
  input  logic [DW-1:0]    im_instr,
  input  logic             id_valid,
  input  logic             redirect,
  input  logic             mem_stall,
  output logic             mux_rf_rn1_select,
  output logic             mux_rf_rn2_select,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             rf_w,
  output logic [RW-1:0]    dest,
  output logic [CNT_W-1:0] stall_count
);

  logic [OPC_W-1:0] opcode_s;
  logic [REG_W-1:0] n1_s;
  logic [REG_W-1:0] n2_s;
  logic [REG_W-1:0] n3_s;
  logic [REG_W-1:0] dest_field_s;
  logic [N3_LO-1:0] unused_imm_s;
  logic             use_n1_s;
  logic             use_n2_s;
  logic             use_n3_s;
  logic             writes_s;
  dest_sel_e        dest_sel_s;
  logic             rn1_sel_s;
  logic             rn2_sel_s;
  logic             hazard_s;
  logic             stall_s;
  logic             bubble_s;
  logic             flush_s;
  logic             rf_w_s;
  logic [RW-1:0]    dest_s;
  stage_t           ex_nxt_s;
  stage_t           ex_r;
  stage_t           mem_r;
  stage_t           wb_r;
  logic [CNT_W-1:0] stall_count_r;

  assign opcode_s     = im_instr[OPC_HI:OPC_LO];
  assign n1_s         = im_instr[N1_HI:N1_LO];
  assign n2_s         = im_instr[N2_HI:N2_LO];
  assign n3_s         = im_instr[N3_HI:N3_LO];
  assign unused_imm_s = im_instr[N3_LO-1:0];

  instr_decode u_decode (
    .opcode   (opcode_s),
    .use_n1   (use_n1_s),
    .use_n2   (use_n2_s),
    .use_n3   (use_n3_s),
    .writes   (writes_s),
    .dest_sel (dest_sel_s),
    .rn1_sel  (rn1_sel_s),
    .rn2_sel  (rn2_sel_s)
  );

  assign dest_field_s = (dest_sel_s == DEST_N1) ? n1_s : n2_s;

  // The RF write lands at the end of step5, so a wb match must still stall.
  assign hazard_s = id_valid &
                    (stage_hit(ex_r,  use_n1_s, use_n2_s, use_n3_s, n1_s, n2_s, n3_s) |
                     stage_hit(mem_r, use_n1_s, use_n2_s, use_n3_s, n1_s, n2_s, n3_s) |
                     stage_hit(wb_r,  use_n1_s, use_n2_s, use_n3_s, n1_s, n2_s, n3_s));

  // Cycle control in priority order: reset, memory freeze, redirect, hazard, issue.
  always_comb begin
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    flush_s  = 1'b0;
    ex_nxt_s = STAGE_NOP;
    if (reset) begin
      stall_s  = 1'b0;
      ex_nxt_s = STAGE_NOP;
    end else if (mem_stall) begin
      stall_s = 1'b1;
    end else if (redirect) begin
      flush_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (hazard_s) begin
      stall_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (id_valid) begin
      ex_nxt_s = '{valid: 1'b1, we: writes_s, dest: dest_field_s};
    end else begin
      ex_nxt_s = STAGE_NOP;
    end
  end

  // In-flight destination tracking for steps 3-5; everything freezes on mem_stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_r  <= STAGE_NOP;
      mem_r <= STAGE_NOP;
      wb_r  <= STAGE_NOP;
    end else if (mem_stall) begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end else begin
      ex_r  <= ex_nxt_s;
      mem_r <= ex_r;
      wb_r  <= mem_r;
    end
  end

  // Saturating count of cycles with stall asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign rf_w_s = ~reset & wb_r.valid & wb_r.we & ~mem_stall;
  assign dest_s = wb_r.valid ? wb_r.dest : {RW{1'b0}};

  assign mux_rf_rn1_select = rn1_sel_s;
  assign mux_rf_rn2_select = rn2_sel_s;
  assign stall             = stall_s;
  assign bubble            = bubble_s;
  assign flush             = flush_s;
  assign rf_w              = rf_w_s;
  assign dest              = dest_s;
  assign stall_count       = stall_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a landing-time register model
// checked every cycle, plus directed scenarios with hand-computed literals.
module tb_pipeline_hazard_ctrl;

  localparam int DW    = 16;
  localparam int RW    = 2;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [DW-1:0]    instr = 16'h0000;
  logic             v     = 1'b0;
  logic             redir = 1'b0;
  logic             ms    = 1'b0;
  logic             rn1_sel;
  logic             rn2_sel;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic             rf_w;
  logic [RW-1:0]    dest;
  logic [CNT_W-1:0] stall_count;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .im_instr          (instr),
    .id_valid          (v),
    .redirect          (redir),
    .mem_stall         (ms),
    .mux_rf_rn1_select (rn1_sel),
    .mux_rf_rn2_select (rn2_sel),
    .stall             (stall),
    .bubble            (bubble),
    .flush             (flush),
    .rf_w              (rf_w),
    .dest              (dest),
    .stall_count       (stall_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every accepted instruction is a record with the cycle its write lands.
  int cyc    = 0;
  int mcount = 0;
  bit p_live [4];
  bit p_we   [4];
  int p_reg  [4];
  int p_land [4];

  function automatic bit m_reads(input logic [15:0] i, input int r);
    int op, a, b, c;
    op = int'(i[15:10]); a = int'(i[9:8]); b = int'(i[7:6]); c = int'(i[5:4]);
    case (op)
      0:       return (b == r) || (c == r);
      1, 2:    return a == r;
      3, 4:    return (a == r) || (b == r);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_writes(input logic [15:0] i);
    return int'(i[15:10]) <= 2;
  endfunction

  function automatic int m_dest(input logic [15:0] i);
    return (i[15:10] == 6'h00) ? int'(i[9:8]) : int'(i[7:6]);
  endfunction

  function automatic bit m_hazard();
    if (!v) return 1'b0;
    for (int k = 0; k < 4; k++)
      if (p_live[k] && p_we[k] && p_land[k] >= cyc && m_reads(instr, p_reg[k])) return 1'b1;
    return 1'b0;
  endfunction

  // Model advance at the active edge.
  always @(posedge clock) begin : model_proc
    bit hz;
    if (reset) begin
      for (int k = 0; k < 4; k++) p_live[k] = 1'b0;
      mcount = 0;
    end else begin
      hz = m_hazard();
      if (ms) begin
        if (mcount < 65535) mcount++;
        for (int k = 0; k < 4; k++) if (p_live[k] && p_land[k] >= cyc) p_land[k]++;
      end else if (redir) begin
        mcount = mcount;
      end else if (hz) begin
        if (mcount < 65535) mcount++;
      end else if (v) begin
        for (int k = 0; k < 4; k++)
          if (!p_live[k]) begin
            p_live[k] = 1'b1; p_we[k] = m_writes(instr);
            p_reg[k] = m_dest(instr); p_land[k] = cyc + 3;
            break;
          end
      end
      for (int k = 0; k < 4; k++) if (p_live[k] && p_land[k] <= cyc) p_live[k] = 1'b0;
      cyc++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin : cmp_proc
    bit hz, wb_hit, wb_we;
    int wb_reg;
    if (!reset) begin
      hz = m_hazard(); wb_hit = 1'b0; wb_we = 1'b0; wb_reg = 0;
      for (int k = 0; k < 4; k++)
        if (p_live[k] && p_land[k] == cyc) begin
          wb_hit = 1'b1; wb_we = p_we[k]; wb_reg = p_reg[k];
        end
      chk("stall",   32'(stall),   32'(ms || (!redir && hz)));
      chk("bubble",  32'(bubble),  32'(!ms && (redir || hz)));
      chk("flush",   32'(flush),   32'(!ms && redir));
      chk("rf_w",    32'(rf_w),    32'(wb_hit && wb_we && !ms));
      chk("dest",    32'(dest),    wb_hit ? wb_reg : 0);
      chk("rn1_sel", 32'(rn1_sel), 32'(instr[15:10] != 6'h00));
      chk("rn2_sel", 32'(rn2_sel), 32'(instr[15:10] != 6'h00));
      chk("stall_count", 32'(stall_count), mcount);
    end
  end

  task automatic drive(input logic [15:0] i, input logic vv, input logic rr, input logic mm);
    @(posedge clock);
    #1;
    instr = i; v = vv; redir = rr; ms = mm;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rst_stall",  32'(stall),       0);
    chk("rst_bubble", 32'(bubble),      0);
    chk("rst_flush",  32'(flush),       0);
    chk("rst_rf_w",   32'(rf_w),        0);
    chk("rst_dest",   32'(dest),        0);
    chk("rst_count",  32'(stall_count), 0);
    instr = 16'h0000; v = 1'b0; redir = 1'b0; ms = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  int exp_dist [5] = '{0, 3, 2, 1, 0};
  int exp_ind  [3] = '{1, 3, 2};
  logic [15:0] mix_i [12] = '{16'h01B0, 16'h1040, 16'h1400, 16'hFC00, 16'h0CC0, 16'h08C0,
                              16'h0700, 16'h0485, 16'h1080, 16'h0000, 16'h0585, 16'h0D40};
  logic        mix_v [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        mix_r [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        mix_m [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #1;
    chk("init_stall", 32'(stall),       0);
    chk("init_rf_w",  32'(rf_w),        0);
    chk("init_count", 32'(stall_count), 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // RAW back-to-back: RTYPE r1 <= r2,r3 then ADDI reading r1.
    drive(16'h01B0, 1'b1, 1'b0, 1'b0);
    drive(16'h0585, 1'b1, 1'b0, 1'b0); at_neg();
    chk("raw_c1_stall",  32'(stall),  1);
    chk("raw_c1_bubble", 32'(bubble), 1);
    drive(16'h0585, 1'b1, 1'b0, 1'b0);
    drive(16'h0585, 1'b1, 1'b0, 1'b0); at_neg();
    chk("raw_c3_rf_w", 32'(rf_w), 1);
    chk("raw_c3_dest", 32'(dest), 1);
    drive(16'h0585, 1'b1, 1'b0, 1'b0); at_neg();
    chk("raw_c4_stall", 32'(stall),       0);
    chk("raw_c4_count", 32'(stall_count), 3);
    repeat (3) drive(16'h0000, 1'b0, 1'b0, 1'b0);
    at_neg();
    chk("raw_c7_rf_w", 32'(rf_w), 1);
    chk("raw_c7_dest", 32'(dest), 2);

    // Distances 2..4 between producer and consumer.
    for (int d = 2; d <= 4; d++) begin
      do_reset();
      drive(16'h01B0, 1'b1, 1'b0, 1'b0);
      repeat (d - 1) drive(16'h0585, 1'b0, 1'b0, 1'b0);
      repeat (5 - d) drive(16'h0585, 1'b1, 1'b0, 1'b0);
      repeat (4) drive(16'h0000, 1'b0, 1'b0, 1'b0);
      at_neg();
      chk("dist_stalls", 32'(stall_count), exp_dist[d]);
    end

    // Independent stream: writes r1, r3, r2 on consecutive cycles.
    do_reset();
    drive(16'h01B0, 1'b1, 1'b0, 1'b0);
    drive(16'h08C0, 1'b1, 1'b0, 1'b0);
    drive(16'h0485, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(16'h0000, 1'b0, 1'b0, 1'b0); at_neg();
      chk("ind_rf_w", 32'(rf_w), 1);
      chk("ind_dest", 32'(dest), exp_ind[k]);
    end
    chk("ind_count", 32'(stall_count), 0);

    // Reset with the pipeline full of writers and a memory stall active.
    do_reset();
    drive(16'h01B0, 1'b1, 1'b0, 1'b0);
    drive(16'h08C0, 1'b1, 1'b0, 1'b0);
    drive(16'h0485, 1'b1, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b1); at_neg();
    chk("midrst_stall", 32'(stall), 1);
    do_reset();
    repeat (5) drive(16'h0000, 1'b0, 1'b0, 1'b0);

    // LW r3 followed by SW reading r3.
    do_reset();
    drive(16'h08C0, 1'b1, 1'b0, 1'b0);
    repeat (4) drive(16'h0CC0, 1'b1, 1'b0, 1'b0);
    at_neg();
    chk("lwsw_stall", 32'(stall),       0);
    chk("lwsw_count", 32'(stall_count), 3);
    chk("lwsw_rn1",   32'(rn1_sel),     1);
    chk("lwsw_rn2",   32'(rn2_sel),     1);

    // Redirect while a hazard is pending drops the dependent ADDI (dest r0).
    do_reset();
    drive(16'h08C0, 1'b1, 1'b0, 1'b0);
    drive(16'h0700, 1'b1, 1'b1, 1'b0); at_neg();
    chk("redir_flush",  32'(flush),  1);
    chk("redir_stall",  32'(stall),  0);
    chk("redir_bubble", 32'(bubble), 1);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0); at_neg();
    chk("redir_lw_dest", 32'(dest), 3);
    drive(16'h0000, 1'b0, 1'b0, 1'b0); at_neg();
    chk("redir_dropped_rf_w", 32'(rf_w), 0);

    // Memory stall for 4 cycles with the writer sitting in wb.
    do_reset();
    drive(16'h01B0, 1'b1, 1'b0, 1'b0);
    repeat (2) drive(16'h0000, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b1); at_neg();
    chk("ms_rf_w",   32'(rf_w),   0);
    chk("ms_bubble", 32'(bubble), 0);
    chk("ms_dest",   32'(dest),   1);
    repeat (3) drive(16'h0000, 1'b0, 1'b0, 1'b1);
    drive(16'h0000, 1'b0, 1'b0, 1'b0); at_neg();
    chk("ms_rel_rf_w", 32'(rf_w),        1);
    chk("ms_rel_dest", 32'(dest),        1);
    chk("ms_count",    32'(stall_count), 4);

    // Mixed directed stream checked by the model only.
    do_reset();
    for (int k = 0; k < 12; k++) drive(mix_i[k], mix_v[k], mix_r[k], mix_m[k]);
    repeat (5) drive(16'h0000, 1'b0, 1'b0, 1'b0);
    at_neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
